// File: rtl/mcse_lc_pkg.sv
// Shared types and result codes for the lifecycle host sequencer.
package mcse_lc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_CHAL = 3'd2,
        ST_AUTH      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_RESP      = 3'd5
    } lc_host_state_t;

    localparam logic [1:0] LC_OK      = 2'b00;
    localparam logic [1:0] LC_FAIL    = 2'b01;
    localparam logic [1:0] LC_TO_CHAL = 2'b10;
    localparam logic [1:0] LC_TO_DONE = 2'b11;

    localparam int unsigned LC_TOKEN_W = 256;

endpackage

// File: rtl/mcse_timeout_ctr.sv
// 16-bit saturating phase timer: clear wins over enable, flag at terminal count.
module mcse_timeout_ctr #(
    parameter int unsigned TERMINAL = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic terminal_o
);
    localparam logic [15:0] TERM_CNT = 16'(TERMINAL);

    logic [15:0] cnt_q, cnt_d;

    // next count: clear, or count up and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal_o = (cnt_q >= TERM_CNT);

endmodule

// File: rtl/lc_host_sequencer.sv
// Host-side lifecycle transition sequencer: request, challenge, authenticate, result.
//
// state        | meaning
// ST_IDLE      | waiting for a host command, cmd_ready high
// ST_REQ       | one-cycle transition request pulse to the MCSE
// ST_WAIT_CHAL | waiting for the MCSE to ask for authentication
// ST_AUTH      | first cycle the authentication token is presented
// ST_WAIT_DONE | token held valid, waiting for DONE or FAIL
// ST_RESP      | result held for the host until rsp_ready
module lc_host_sequencer
    import mcse_lc_pkg::*;
#(
    parameter int unsigned gpio_N         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned AUTH_REQ_BIT   = 0,
    parameter int unsigned DONE_BIT       = 1,
    parameter int unsigned FAIL_BIT       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LC_TOKEN_W-1:0] cmd_transition_id,
    input  logic [LC_TOKEN_W-1:0] cmd_auth_id,
    input  logic [gpio_N-1:0]     mcse_status,
    output logic [LC_TOKEN_W-1:0] lc_transition_id,
    output logic                  lc_transition_request,
    output logic [LC_TOKEN_W-1:0] lc_authentication_id,
    output logic                  lc_authentication_valid,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic                  busy
);
    lc_host_state_t        state_q, state_d;
    logic [LC_TOKEN_W-1:0] trans_q, trans_d;
    logic [LC_TOKEN_W-1:0] auth_q, auth_d;
    logic [1:0]            rsp_q, rsp_d;
    logic                  in_wait;
    logic                  timed_out;

    // status bits beyond the three decoded flags carry MCSE outputs not consumed here
    logic unused_status;
    assign unused_status = ^mcse_status;

    assign in_wait = (state_q == ST_WAIT_CHAL) || (state_q == ST_WAIT_DONE);

    mcse_timeout_ctr #(
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (!in_wait),
        .en_i       (in_wait),
        .terminal_o (timed_out)
    );

    // next-state, token capture and result code selection
    always_comb begin
        state_d = state_q;
        trans_d = trans_q;
        auth_d  = auth_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    trans_d = cmd_transition_id;
                    auth_d  = cmd_auth_id;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: state_d = ST_WAIT_CHAL;
            ST_WAIT_CHAL: begin
                if (mcse_status[AUTH_REQ_BIT]) begin
                    state_d = ST_AUTH;
                end else if (timed_out) begin
                    rsp_d   = LC_TO_CHAL;
                    state_d = ST_RESP;
                end
            end
            ST_AUTH: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // FAIL outranks a coincident DONE
                if (mcse_status[FAIL_BIT]) begin
                    rsp_d   = LC_FAIL;
                    state_d = ST_RESP;
                end else if (mcse_status[DONE_BIT]) begin
                    rsp_d   = LC_OK;
                    state_d = ST_RESP;
                end else if (timed_out) begin
                    rsp_d   = LC_TO_DONE;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // state, token and result registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            trans_q <= '0;
            auth_q  <= '0;
            rsp_q   <= LC_OK;
        end else begin
            state_q <= state_d;
            trans_q <= trans_d;
            auth_q  <= auth_d;
            rsp_q   <= rsp_d;
        end
    end

    assign cmd_ready               = (state_q == ST_IDLE);
    assign busy                    = (state_q != ST_IDLE);
    assign lc_transition_id        = trans_q;
    assign lc_authentication_id    = auth_q;
    assign lc_transition_request   = (state_q == ST_REQ);
    assign lc_authentication_valid = (state_q == ST_AUTH) || (state_q == ST_WAIT_DONE);
    assign rsp_valid               = (state_q == ST_RESP);
    assign rsp_status              = rsp_q;

endmodule

// File: doc/lc_host_sequencer.md
LC_HOST_SEQUENCER -- requirements
Module: lc_host_sequencer

Interface
REQ-001 Parameter gpio_N, default 32: width of the MCSE status bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum wait per phase, in cycles; legal range 2..65535.
REQ-003 Parameter AUTH_REQ_BIT / DONE_BIT / FAIL_BIT, defaults 0 / 1 / 2: status bit positions within mcse_status.
REQ-004 clk  input  1  single clock for the whole block.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cmd_valid  input  1  host command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_transition_id  input  256  requested lifecycle transition token.
REQ-009 cmd_auth_id  input  256  authentication token for the transition.
REQ-010 mcse_status  input  gpio_N  MCSE gpio_out, sampled as the status bus.
REQ-011 lc_transition_id  output  256  transition token presented to the MCSE.
REQ-012 lc_transition_request  output  1  single-cycle transition request pulse.
REQ-013 lc_authentication_id  output  256  authentication token presented to the MCSE.
REQ-014 lc_authentication_valid  output  1  authentication token valid (level).
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  host accepts the result.
REQ-017 rsp_status  output  2  result code: 00 OK, 01 FAIL, 10 TIMEOUT_CHAL, 11 TIMEOUT_DONE.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, REQ, WAIT_CHAL, AUTH, WAIT_DONE, RESP.
REQ-020 cmd_ready = 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both high on a clk edge.
REQ-021 On acceptance: both tokens are latched into internal registers, lc_transition_id is driven from the latched value, and the next state is REQ.
REQ-022 REQ lasts exactly one cycle with lc_transition_request = 1; it then goes to WAIT_CHAL and clears the timeout counter.
REQ-023 WAIT_CHAL: if mcse_status[AUTH_REQ_BIT] = 1, go to AUTH; if the counter reaches TIMEOUT_CYCLES-1 without that bit, go to RESP with code 10.
REQ-024 AUTH lasts one cycle: drive lc_authentication_id from the latched token, set lc_authentication_valid = 1, go to WAIT_DONE, and clear the counter.
REQ-025 WAIT_DONE: lc_authentication_valid stays 1.
  - FAIL_BIT = 1 -> RESP with code 01.
  - Else DONE_BIT = 1 -> RESP with code 00.
  - Else counter reaches TIMEOUT_CYCLES-1 -> RESP with code 11.
REQ-026 If FAIL_BIT and DONE_BIT are set in the same cycle, FAIL has priority.
REQ-027 lc_authentication_valid deasserts on the cycle the FSM enters RESP.
REQ-028 RESP: rsp_valid = 1 and rsp_status is held stable until rsp_ready = 1; then return to IDLE.
REQ-029 rsp_ready high in the same cycle RESP is entered completes the handshake in one cycle.
REQ-030 Timeout counter: 16 bits, increments only in WAIT_CHAL and WAIT_DONE, saturates, and never wraps.
REQ-031 Status bits are sampled directly, with no synchronizer, because mcse_status is in the clk domain.
REQ-032 In IDLE, lc_transition_id and lc_authentication_id hold their last values; they change only on command acceptance.
REQ-033 cmd_valid while busy is ignored; there is no command queueing.

Reset
REQ-034 Synchronous rst forces the following on the next clk edge, regardless of state (including mid-transaction):
  - state = IDLE and counter = 0;
  - both token registers, lc_transition_id and lc_authentication_id = 0;
  - lc_transition_request = 0, lc_authentication_valid = 0;
  - rsp_valid = 0, rsp_status = 00, busy = 0;
  - cmd_ready = 1 from the first cycle after reset.
REQ-035 A transaction interrupted by rst produces no response.

Structure
REQ-036 Shared package mcse_lc_pkg holds the state enum lc_host_state_t and the rsp_status code constants LC_OK, LC_FAIL, LC_TO_CHAL and LC_TO_DONE.
REQ-037 One sub-module, mcse_timeout_ctr, is natural: a saturating counter with clear, enable and a terminal flag. All other logic stays in lc_host_sequencer.

Verification
REQ-038 Nominal pass: tokens A/B accepted; AUTH_REQ set 3 cycles after the request pulse; DONE 5 cycles after valid -> request pulse exactly 1 cycle wide, valid high 6 cycles, rsp_status = 00.
REQ-039 Rejection: FAIL and DONE set in the same cycle -> rsp_status = 01, valid drops on RESP entry.
REQ-040 Challenge timeout: TIMEOUT_CYCLES = 8, AUTH_REQ never set -> RESP with code 10 exactly 8 cycles after the WAIT_CHAL entry; lc_authentication_valid never asserted.
REQ-041 Done timeout: AUTH_REQ set, DONE never set, TIMEOUT_CYCLES = 8 -> code 11 after 8 cycles in WAIT_DONE.
REQ-042 Backpressure and reset: rsp_ready held low 10 cycles -> rsp_valid and rsp_status stable throughout. Separately, rst asserted in WAIT_DONE -> all outputs at reset values next cycle, no rsp_valid.
REQ-043 Busy drop: a second cmd_valid during WAIT_CHAL is not accepted, cmd_ready = 0, and the latched tokens are unchanged.
